// File: rtl/grant_tracker_pkg.sv
// Shared parameters and slot-state type for the grant tracker.
package grant_tracker_pkg;
  localparam int unsigned N     = 8;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned CNT_W = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;
endpackage

// File: rtl/onehot_encode.sv
// One-hot to binary encoder; also reports whether the input is exactly one-hot.
module onehot_encode
  import grant_tracker_pkg::*;
(
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             is_onehot
);
  logic [IDX_W:0] ones;

  always_comb begin
    idx  = '0;
    ones = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (vec[i]) begin
        idx  = idx | IDX_W'(i);
        ones = ones + (IDX_W+1)'(1);
      end
    end
    is_onehot = (ones == (IDX_W+1)'(1));
  end
endmodule

// File: rtl/grant_tracker.sv
// Sticky request tracker feeding a priority arbiter; forwards each granted
// index to a consumer through a single-entry valid/ready slot.
module grant_tracker
  import grant_tracker_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req_pulse,
  output logic [N-1:0]     pending,
  input  logic [N-1:0]     grant,
  output logic             idx_valid,
  output logic [IDX_W-1:0] idx,
  input  logic             idx_ready,
  output logic [CNT_W-1:0] grant_count,
  output logic             overrun,
  output logic             grant_err
);
  slot_state_t     state, state_next;
  logic [IDX_W-1:0] grant_idx;
  logic            grant_onehot;
  logic            grant_ok;
  logic            handshake;
  logic            slot_free;
  logic            take;
  logic [N-1:0]    clear;

  onehot_encode u_enc (
    .vec       (grant),
    .idx       (grant_idx),
    .is_onehot (grant_onehot)
  );

  // A grant is only consumed when the slot can accept it this cycle;
  // otherwise the bit stays pending and the arbiter re-offers it later.
  always_comb begin
    idx_valid  = (state == FULL);
    handshake  = idx_valid & idx_ready;
    slot_free  = (state == EMPTY) | handshake;
    grant_ok   = grant_onehot & ((grant & ~pending) == '0);
    take       = slot_free & grant_ok;
    clear      = take ? grant : '0;
    state_next = state;
    if (take)
      state_next = FULL;
    else if (handshake)
      state_next = EMPTY;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= EMPTY;
    else
      state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending     <= '0;
      idx         <= '0;
      grant_count <= '0;
      overrun     <= 1'b0;
      grant_err   <= 1'b0;
    end else begin
      pending <= (pending & ~clear) | req_pulse;
      if (take)
        idx <= grant_idx;
      if (handshake)
        grant_count <= grant_count + CNT_W'(1);
      if ((req_pulse & pending & ~clear) != '0)
        overrun <= 1'b1;
      if ((grant != '0) && !grant_ok)
        grant_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_grant_tracker.sv
// Randomized scoreboard bench for grant_tracker with a behavioural reference model.
module tb_grant_tracker;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] req_pulse = '0;
  logic [7:0] pending;
  logic [7:0] grant;
  logic       idx_valid;
  logic [2:0] idx;
  logic       idx_ready = 1'b0;
  logic [7:0] grant_count;
  logic       overrun;
  logic       grant_err;

  logic       force_en = 1'b0;
  logic [7:0] force_val = '0;
  logic [7:0] arb_grant;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0] m_pend = '0;
  bit         m_full = 0;
  logic [7:0] m_cnt = '0;
  bit         m_ovr = 0;
  bit         m_gerr = 0;
  int         q[$];

  always #5 clk = ~clk;

  // lowest-index priority arbiter
  assign arb_grant = pending & (~pending + 8'd1);
  assign grant     = force_en ? force_val : arb_grant;

  grant_tracker dut (
    .clk         (clk),
    .reset       (reset),
    .req_pulse   (req_pulse),
    .pending     (pending),
    .grant       (grant),
    .idx_valid   (idx_valid),
    .idx         (idx),
    .idx_ready   (idx_ready),
    .grant_count (grant_count),
    .overrun     (overrun),
    .grant_err   (grant_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest_index(input logic [7:0] v);
    for (int i = 0; i < 8; i++)
      if (v[i]) return i;
    return -1;
  endfunction

  // Model advances on the same edge the DUT samples, from the rules alone.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pend = '0; m_full = 0; m_cnt = '0; m_ovr = 0; m_gerr = 0;
      q.delete();
    end else begin
      logic [7:0] g, clr;
      bit hs, ok, take;
      int lo;
      lo   = lowest_index(m_pend);
      g    = force_en ? force_val : ((lo < 0) ? 8'h00 : 8'(1 << lo));
      hs   = m_full && idx_ready;
      ok   = ($countones(g) == 1) && ((g & ~m_pend) == 8'h00);
      take = (!m_full || hs) && ok;
      if (g != 8'h00 && !ok) m_gerr = 1;
      clr = take ? g : 8'h00;
      if ((req_pulse & m_pend & ~clr) != 8'h00) m_ovr = 1;
      m_pend = (m_pend & ~clr) | req_pulse;
      if (hs) m_cnt = m_cnt + 8'd1;
      if (take) q.push_back(lowest_index(g));
      m_full = take || (m_full && !hs);
    end
  end

  // Monitor: compares state mid-cycle and pops expected index on each handshake.
  always @(negedge clk) begin
    check("pending", 32'(pending), 32'(m_pend));
    check("idx_valid", 32'(idx_valid), 32'(m_full));
    check("grant_count", 32'(grant_count), 32'(m_cnt));
    check("overrun", 32'(overrun), 32'(m_ovr));
    check("grant_err", 32'(grant_err), 32'(m_gerr));
    if (idx_valid && idx_ready) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL idx_unexpected actual=%0d expected=none at %0t", idx, $time);
      end else begin
        int e;
        e = q.pop_front();
        check("idx", 32'(idx), 32'(e));
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; force_en = 1'b0; req_pulse = '0; idx_ready = 1'b0;
    cycle(); cycle();
    reset = 1'b0;
  endtask

  initial begin
    do_reset();

    // burst of two requests, consumer always ready
    idx_ready = 1'b1; req_pulse = 8'b0000_0110;
    cycle(); req_pulse = '0;
    repeat (5) cycle();
    check("t1_pending", 32'(pending), 32'h0);
    check("t1_count", 32'(grant_count), 32'd2);
    check("t1_valid", 32'(idx_valid), 32'd0);

    // stalled consumer holds index stable
    do_reset();
    req_pulse = 8'b0010_0000;
    cycle(); req_pulse = '0;
    cycle();
    for (int i = 0; i < 4; i++) begin
      check("t2_hold_valid", 32'(idx_valid), 32'd1);
      check("t2_hold_idx", 32'(idx), 32'd5);
      cycle();
    end
    check("t2_pending", 32'(pending), 32'h0);
    idx_ready = 1'b1;
    cycle(); idx_ready = 1'b0;
    cycle();
    check("t2_count", 32'(grant_count), 32'd1);

    // set/clear collision then a genuine overrun
    do_reset();
    idx_ready = 1'b1; req_pulse = 8'b0000_0100;
    cycle();
    cycle();
    check("t3_pending", 32'(pending), 32'h04);
    check("t3_idx", 32'(idx), 32'd2);
    check("t3_overrun0", 32'(overrun), 32'd0);
    idx_ready = 1'b0; req_pulse = '0;
    cycle(); req_pulse = 8'b0000_0100;
    cycle(); req_pulse = '0;
    check("t3_overrun1", 32'(overrun), 32'd1);

    // illegal grants
    for (int k = 0; k < 2; k++) begin
      do_reset();
      idx_ready = 1'b1; force_en = 1'b1;
      force_val = (k == 0) ? 8'b0000_0011 : 8'b0001_0000;
      req_pulse = 8'b0000_0001;
      cycle(); req_pulse = '0;
      cycle(); cycle();
      check("t4_grant_err", 32'(grant_err), 32'd1);
      check("t4_pending", 32'(pending), 32'h01);
      check("t4_valid", 32'(idx_valid), 32'd0);
      force_en = 1'b0;
      repeat (3) cycle();
    end

    // asynchronous reset mid-burst
    do_reset();
    req_pulse = 8'b1101_1110;
    cycle(); req_pulse = 8'b0000_0010;
    cycle(); req_pulse = '0;
    check("t5_pre_pending", 32'(pending), 32'hDE);
    check("t5_pre_valid", 32'(idx_valid), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("t5_pending", 32'(pending), 32'h0);
    check("t5_valid", 32'(idx_valid), 32'd0);
    check("t5_idx", 32'(idx), 32'd0);
    check("t5_count", 32'(grant_count), 32'd0);
    check("t5_flags", 32'({overrun, grant_err}), 32'd0);

    // 256 single requests wrap the counter
    do_reset();
    idx_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      req_pulse = 8'(1 << $urandom_range(0, 7));
      cycle();
    end
    req_pulse = '0;
    repeat (10) cycle();
    check("t6_count_wrap", 32'(grant_count), 32'd0);
    check("t6_idle_valid", 32'(idx_valid), 32'd0);

    // randomized traffic, stalls and occasional forced grants
    do_reset();
    for (int i = 0; i < 600; i++) begin
      req_pulse = ($urandom_range(0, 2) == 0) ? (8'($urandom) & 8'($urandom)) : 8'h00;
      idx_ready = ($urandom_range(0, 2) != 0);
      force_en  = ($urandom_range(0, 15) == 0);
      force_val = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(0, 7));
      cycle();
    end
    req_pulse = '0; force_en = 1'b0; idx_ready = 1'b1;
    begin
      int budget;
      budget = 0;
      while ((m_pend != 8'h00 || m_full) && budget < 50) begin
        cycle();
        budget++;
      end
      cycle();
      check("drain_timeout", 32'(budget < 50), 32'd1);
      check("drain_queue", 32'(q.size()), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
